// File: rtl/egg_timer_ctl.sv
// Egg timer controller: debounced start/pause button, prescaled countdown,
// pause/resume and a timed blinking alarm.
module egg_timer_ctl #(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned PRESCALE    = 50000000,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned ALARM_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn,
  input  logic [SIZE-1:0] max,
  output logic [SIZE-1:0] led,
  output logic            busy,
  output logic            done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  logic [1:0]      sync_q;
  logic            btn_s;
  logic            deb_q;
  logic            deb_prev_q;
  logic [DW-1:0]   deb_cnt_q;
  logic            press_c;
  logic            tick_c;

  state_t          state_q, state_n;
  logic [SIZE-1:0] count_q, count_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic [AW-1:0]   atc_q, atc_n;
  logic            blink_q, blink_n;
  logic [SIZE-1:0] led_n;
  logic            busy_n, done_n;

  assign btn_s   = sync_q[1];
  assign press_c = deb_q & ~deb_prev_q;
  assign tick_c  = (presc_q == PW'(PRESCALE - 1));

  // Two-flop synchroniser for the asynchronous button pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Debouncer: flip only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (btn_s == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_q     <= btn_s;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      presc_q <= '0;
      atc_q   <= '0;
      blink_q <= 1'b0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      presc_q <= presc_n;
      atc_q   <= atc_n;
      blink_q <= blink_n;
      led     <= led_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // register in step with it.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    presc_n = presc_q;
    atc_n   = atc_q;
    blink_n = blink_q;
    led_n   = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        presc_n = '0;
        if (press_c) begin
          if (max != '0) begin
            count_n = max;
            state_n = S_RUN;
          end else begin
            blink_n = 1'b0;
            atc_n   = '0;
            state_n = S_ALARM;
          end
        end
      end
      S_RUN: begin
        if (press_c) begin
          state_n = S_PAUSE;
        end else if (tick_c) begin
          presc_n = '0;
          if (count_q > SIZE'(1)) begin
            count_n = count_q - SIZE'(1);
          end else begin
            count_n = '0;
            blink_n = 1'b0;
            atc_n   = '0;
            state_n = S_ALARM;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (press_c) begin
          state_n = S_RUN;
        end
      end
      S_ALARM: begin
        if (press_c) begin
          presc_n = '0;
          state_n = S_IDLE;
        end else if (tick_c) begin
          presc_n = '0;
          blink_n = ~blink_q;
          atc_n   = atc_q + AW'(1);
          if ((ALARM_TICKS != 0) && (atc_q == AW'(ALARM_TICKS - 1))) begin
            state_n = S_IDLE;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    unique case (state_n)
      S_RUN, S_PAUSE: begin
        led_n  = count_n;
        busy_n = 1'b1;
      end
      S_ALARM: begin
        led_n  = {SIZE{blink_n}};
        done_n = 1'b1;
      end
      default: led_n = '0;
    endcase
  end

endmodule

// File: tb/tb_egg_timer_ctl.sv
// Self-checking bench for egg_timer_ctl: directed scenarios plus random
// button/switch activity against a behavioural reference model.
module tb_egg_timer_ctl;

  localparam int unsigned SIZE        = 4;
  localparam int unsigned PRESCALE    = 4;
  localparam int unsigned DEB_CYCLES  = 3;
  localparam int unsigned ALARM_TICKS = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic            clk;
  logic            rst_n;
  logic            btn;
  logic [SIZE-1:0] max;
  logic [SIZE-1:0] led;
  logic            busy;
  logic            done;

  int n_cmp;
  int n_bad;

  // Reference model state (plain integers describing the timer's behaviour).
  int m_mode;
  int m_rem;
  int m_elapsed;
  int m_lit;
  int m_alarm_ticks;
  int m_run_len;
  bit m_s1, m_s2, m_deb, m_pend;
  bit m_press, m_tick;

  egg_timer_ctl #(
    .SIZE(SIZE), .PRESCALE(PRESCALE), .DEB_CYCLES(DEB_CYCLES), .ALARM_TICKS(ALARM_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .max(max), .led(led), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_elapsed = 0; m_lit = 0; m_alarm_ticks = 0;
    m_run_len = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_pend = 0;
  endtask

  // One clock of the reference model, using values present before the edge.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_press = m_pend;
      m_tick  = (m_elapsed == int'(PRESCALE) - 1);
      case (m_mode)
        M_IDLE: begin
          m_elapsed = 0;
          if (m_press) begin
            if (int'(max) != 0) begin m_rem = int'(max); m_mode = M_RUN; end
            else begin m_mode = M_ALARM; m_lit = 0; m_alarm_ticks = 0; end
          end
        end
        M_RUN: begin
          if (m_press) m_mode = M_PAUSE;
          else if (m_tick) begin
            m_elapsed = 0;
            if (m_rem > 1) m_rem = m_rem - 1;
            else begin m_rem = 0; m_mode = M_ALARM; m_lit = 0; m_alarm_ticks = 0; end
          end else m_elapsed = m_elapsed + 1;
        end
        M_PAUSE: if (m_press) m_mode = M_RUN;
        default: begin
          if (m_press) begin m_mode = M_IDLE; m_elapsed = 0; end
          else if (m_tick) begin
            m_elapsed = 0;
            m_lit = 1 - m_lit;
            m_alarm_ticks = m_alarm_ticks + 1;
            if (ALARM_TICKS != 0 && m_alarm_ticks == int'(ALARM_TICKS)) m_mode = M_IDLE;
          end else m_elapsed = m_elapsed + 1;
        end
      endcase
      // Button: a level is accepted after DEB_CYCLES consecutive disagreeing samples.
      m_pend = 1'b0;
      if (m_s2 != m_deb) begin
        m_run_len = m_run_len + 1;
        if (m_run_len == int'(DEB_CYCLES)) begin
          m_deb = m_s2; m_run_len = 0; m_pend = m_deb;
        end
      end else m_run_len = 0;
      m_s2 = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic check_model();
    int e_led;
    logic [31:0] expv;
    if (m_mode == M_IDLE) e_led = 0;
    else if (m_mode == M_ALARM) e_led = (m_lit != 0) ? (1 << SIZE) - 1 : 0;
    else e_led = m_rem;
    expv = 32'((e_led << 2) | ((m_mode == M_RUN || m_mode == M_PAUSE) ? 2 : 0) |
               ((m_mode == M_ALARM) ? 1 : 0));
    chk("model_led_busy_done", 32'({led, busy, done}), expv);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
    end
  endtask

  // Clean press: returns on the negedge right after the FSM acted on it.
  task automatic push();
    btn = 1'b1;
    cyc(3);
    btn = 1'b0;
    cyc(3);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_mode == M_IDLE) break;
      cyc(1);
    end
    chk("idle_reached", 32'({led, busy, done}), 32'd0);
  endtask

  initial begin
    int t;
    int hi;
    int hold;
    n_cmp = 0; n_bad = 0;
    btn = 1'b0; max = '0; rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_flags", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Basic countdown with a 10-cycle press.
    max = 4'd3; btn = 1'b1;
    cyc(5);  chk("t1_no_start_yet", 32'(busy), 32'd0);
    cyc(1);  chk("t1_busy", 32'(busy), 32'd1); chk("t1_led3", 32'(led), 32'd3);
    cyc(3);  chk("t1_led3_hold", 32'(led), 32'd3);
    cyc(1);  chk("t1_led2", 32'(led), 32'd2);
    btn = 1'b0;
    cyc(4);  chk("t1_led1", 32'(led), 32'd1);
    cyc(4);  chk("t1_alarm", 32'({led, busy, done}), 32'h01);
    cyc(4);  chk("t1_blink_on", 32'(led), 32'hf);
    cyc(4);  chk("t1_blink_off", 32'(led), 32'h0);
    cyc(4);  chk("t1_blink_on2", 32'(led), 32'hf);
    cyc(4);  chk("t1_idle", 32'({led, busy, done}), 32'h00);

    // Bounce rejection.
    t = 0;
    while (t < 20) begin
      hi = int'($urandom_range(1, 2));
      btn = 1'b1; cyc(hi);
      btn = 1'b0; cyc(1);
      t = t + hi + 1;
    end
    cyc(3);
    chk("t2_bounce_idle", 32'({led, busy, done}), 32'h00);
    max = 4'd2; btn = 1'b1;
    cyc(5);  chk("t2_no_start_yet", 32'(busy), 32'd0);
    cyc(1);  chk("t2_start", 32'({led, busy}), 32'h5);
    btn = 1'b0;
    wait_idle(40);

    // Pause/resume with the prescaler held mid-period.
    cyc(3);
    max = 4'd5;
    push();  chk("t3_led5", 32'(led), 32'd5);
    cyc(1);
    push();  chk("t3_paused", 32'({led, busy}), 32'h9);
    cyc(100); chk("t3_pause_hold", 32'({led, busy, done}), 32'h12);
    push();  chk("t3_resumed", 32'(led), 32'd4);
    cyc(1);  chk("t3_resume_1", 32'(led), 32'd4);
    cyc(1);  chk("t3_resume_dec", 32'(led), 32'd3);
    wait_idle(60);

    // max==0 goes straight to ALARM; press (coinciding with a tick) exits.
    max = 4'd0;
    push();  chk("t4_alarm_direct", 32'({led, busy, done}), 32'h01);
    cyc(2);
    push();  chk("t4_press_exit", 32'({led, busy, done}), 32'h00);

    // Press on the final tick pauses at count 1.
    cyc(2);
    max = 4'd2;
    push();  chk("t5_led2", 32'(led), 32'd2);
    cyc(2);
    push();  chk("t5_paused_at_1", 32'({led, busy, done}), 32'h06);
    cyc(2);  chk("t5_pause_hold", 32'({led, busy, done}), 32'h06);
    push();  chk("t5_resumed", 32'({led, busy}), 32'h3);
    cyc(1);  chk("t5_alarm", 32'({led, busy, done}), 32'h01);
    wait_idle(30);

    // max change during RUN is ignored; then async reset mid-RUN.
    cyc(2);
    max = 4'd5;
    push();
    max = 4'd9;
    cyc(2);  chk("t6_led5", 32'(led), 32'd5);
    cyc(3);  chk("t6_led4", 32'(led), 32'd4);
    cyc(8);  chk("t6_led2", 32'(led), 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_async_reset", 32'({led, busy, done}), 32'h00);
    btn = 1'b1; max = 4'd3;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);  chk("t7_no_start_yet", 32'(busy), 32'd0);
    cyc(1);  chk("t7_start_after_reset", 32'({led, busy}), 32'h7);
    btn = 1'b0;
    wait_idle(40);

    // Random button and switch activity against the model.
    for (int k = 0; k < 300; k++) begin
      hold = int'($urandom_range(1, 8));
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) max = SIZE'($urandom);
      cyc(hold);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rand_async_reset", 32'({led, busy, done}), 32'h00);
        cyc(2);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
